// File: rtl/csa_pkg.sv
// Shared types and sizing for the carry-save stream accumulator.
package csa_pkg;

   localparam int unsigned DEF_WIDTH       = 16;
   localparam int unsigned DEF_GUARD       = 4;
   localparam int unsigned DEF_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OUT     = 2'd2
   } state_t;

   // Accumulator width: operand width plus guard bits.
   function automatic int unsigned acc_width(input int unsigned width, input int unsigned guard);
      return width + guard;
   endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational row of full adders: three operands in, sum and unshifted carry out.
module csa_row #(
   parameter int unsigned W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   // Bitwise 3:2 compression.
   always_comb begin
      sum   = a ^ b ^ c;
      carry = (a & b) | (a & c) | (b & c);
   end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Accumulates a valid/ready operand stream in carry-save form and resolves
// one sum per frame with a single carry-propagate add after the last beat.
module csa_stream_accumulator
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned GUARD       = DEF_GUARD,
   parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
   localparam int unsigned ACC_WIDTH  = acc_width(WIDTH, GUARD)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_WIDTH-1:0]   out_sum,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   out_overflow
);

   state_t                 state;
   state_t                 state_next;
   logic                   take;
   logic                   resolve;
   logic                   release_out;

   logic [ACC_WIDTH-1:0]   s_q;
   logic [ACC_WIDTH-1:0]   c_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   ovf_q;

   logic [ACC_WIDTH-1:0]   operand;
   logic [ACC_WIDTH-1:0]   row_sum;
   logic [ACC_WIDTH-1:0]   row_carry;
   logic [ACC_WIDTH:0]     total;
   logic [COUNT_WIDTH-1:0] count_inc;

   assign operand = ACC_WIDTH'(in_data);

   csa_row #(
      .W(ACC_WIDTH)
   ) u_row (
      .a    (s_q),
      .b    (c_q),
      .c    (operand),
      .sum  (row_sum),
      .carry(row_carry)
   );

   // Final carry-propagate add with carry-out, and saturating beat count.
   always_comb begin
      total     = (ACC_WIDTH + 1)'(s_q) + (ACC_WIDTH + 1)'(c_q);
      count_inc = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + COUNT_WIDTH'(1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control strobes.
   always_comb begin
      state_next  = state;
      take        = 1'b0;
      resolve     = 1'b0;
      release_out = 1'b0;
      case (state)
         ST_ACCUM: begin
            if (in_valid && in_ready) begin
               take = 1'b1;
               if (in_last) begin
                  state_next = ST_RESOLVE;
               end
            end
         end
         ST_RESOLVE: begin
            resolve    = 1'b1;
            state_next = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               release_out = 1'b1;
               state_next  = ST_ACCUM;
            end
         end
         default: begin
            state_next = ST_ACCUM;
         end
      endcase
   end

   // Carry-save accumulator, result registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q          <= '0;
         c_q          <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
         in_ready     <= 1'b1;
      end else begin
         in_ready <= (state_next == ST_ACCUM);
         if (take) begin
            s_q     <= row_sum;
            c_q     <= {row_carry[ACC_WIDTH-2:0], 1'b0};
            ovf_q   <= ovf_q | row_carry[ACC_WIDTH-1];
            count_q <= count_inc;
         end
         if (resolve) begin
            out_sum      <= total[ACC_WIDTH-1:0];
            out_count    <= count_q;
            out_overflow <= ovf_q | total[ACC_WIDTH];
            out_valid    <= 1'b1;
         end
         if (release_out) begin
            out_valid <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
         end
      end
   end

endmodule
